// File: rtl/lvds_panel_power_seq.sv
// Power/enable sequencer for an LVDS LCD panel: VDD -> LVDS -> backlight on the way up,
// reverse order on the way down, with an underflow watchdog. Optional PWM via LVDS_BL_PWM_EN.
module lvds_panel_power_seq #(
  parameter int CW         = 24,
  parameter int T_VDD_LVDS = 4,
  parameter int T_LVDS_BL  = 3,
  parameter int T_BL_LVDS  = 2,
  parameter int T_LVDS_VDD = 2,
  parameter int T_OFF_MIN  = 5,
  parameter int UF_LIMIT   = 8,
  parameter int PWM_DIV    = 1
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic       panel_en,
  input  logic       vid_underflow,
  input  logic [7:0] brightness,
  output logic       panel_vdd_en,
  output logic       lvds_tx_en,
  output logic       bl_en,
  output logic       bl_pwm,
  output logic       panel_ready,
  output logic       fault,
  output logic [2:0] state_o
);

  localparam logic [2:0] S_OFF      = 3'd0;
  localparam logic [2:0] S_VDD_UP   = 3'd1;
  localparam logic [2:0] S_LVDS_UP  = 3'd2;
  localparam logic [2:0] S_ON       = 3'd3;
  localparam logic [2:0] S_BL_DN    = 3'd4;
  localparam logic [2:0] S_LVDS_DN  = 3'd5;
  localparam logic [2:0] S_OFF_WAIT = 3'd6;

  localparam int UW = $clog2(UF_LIMIT + 1);

  localparam logic [CW-1:0] LD_VDD_LVDS = CW'(T_VDD_LVDS - 1);
  localparam logic [CW-1:0] LD_LVDS_BL  = CW'(T_LVDS_BL - 1);
  localparam logic [CW-1:0] LD_BL_LVDS  = CW'(T_BL_LVDS - 1);
  localparam logic [CW-1:0] LD_LVDS_VDD = CW'(T_LVDS_VDD - 1);
  localparam logic [CW-1:0] LD_OFF_MIN  = CW'(T_OFF_MIN - 1);

  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt, cnt_dec;
  logic [UW-1:0] uf_cnt, uf_cnt_nxt;
  logic          fault_nxt;
  logic          uf_hit, uf_trip;

  assign cnt_dec = (cnt == '0) ? cnt : cnt - 1'b1;

  // Trip fires on the cycle whose underflow would bring the run length to UF_LIMIT.
  assign uf_hit  = (state == S_ON) && vid_underflow;
  assign uf_trip = uf_hit && (uf_cnt >= UW'(UF_LIMIT - 1));

  always_comb begin
    uf_cnt_nxt = '0;
    if (uf_hit) begin
      uf_cnt_nxt = (uf_cnt == UW'(UF_LIMIT)) ? uf_cnt : uf_cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_dec;
    fault_nxt = fault;
    case (state)
      S_OFF: begin
        cnt_nxt = '0;
        if (!panel_en) begin
          fault_nxt = 1'b0;
        end else if (!fault) begin
          state_nxt = S_VDD_UP;
          cnt_nxt   = LD_VDD_LVDS;
        end
      end
      S_VDD_UP: begin
        if (!panel_en) begin
          state_nxt = S_OFF_WAIT;
          cnt_nxt   = LD_OFF_MIN;
        end else if (cnt == '0) begin
          state_nxt = S_LVDS_UP;
          cnt_nxt   = LD_LVDS_BL;
        end
      end
      S_LVDS_UP: begin
        if (!panel_en) begin
          state_nxt = S_LVDS_DN;
          cnt_nxt   = LD_LVDS_VDD;
        end else if (cnt == '0) begin
          state_nxt = S_ON;
        end
      end
      S_ON: begin
        if (!panel_en || uf_trip) begin
          state_nxt = S_BL_DN;
          cnt_nxt   = LD_BL_LVDS;
        end
        if (uf_trip) fault_nxt = 1'b1;
      end
      S_BL_DN: begin
        if (cnt == '0) begin
          state_nxt = S_LVDS_DN;
          cnt_nxt   = LD_LVDS_VDD;
        end
      end
      S_LVDS_DN: begin
        if (cnt == '0) begin
          state_nxt = S_OFF_WAIT;
          cnt_nxt   = LD_OFF_MIN;
        end
      end
      S_OFF_WAIT: begin
        if (cnt == '0) state_nxt = S_OFF;
      end
      default: begin
        state_nxt = S_OFF_WAIT;
        cnt_nxt   = LD_OFF_MIN;
      end
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state  <= S_OFF;
      cnt    <= '0;
      uf_cnt <= '0;
      fault  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      uf_cnt <= uf_cnt_nxt;
      fault  <= fault_nxt;
    end
  end

  // Enables decode straight from the state register so a reset drops them immediately.
  always_comb begin
    panel_vdd_en = 1'b0;
    lvds_tx_en   = 1'b0;
    bl_en        = 1'b0;
    case (state)
      S_VDD_UP:  panel_vdd_en = 1'b1;
      S_LVDS_UP: begin panel_vdd_en = 1'b1; lvds_tx_en = 1'b1; end
      S_ON:      begin panel_vdd_en = 1'b1; lvds_tx_en = 1'b1; bl_en = 1'b1; end
      S_BL_DN:   begin panel_vdd_en = 1'b1; lvds_tx_en = 1'b1; end
      S_LVDS_DN: panel_vdd_en = 1'b1;
      default: ;
    endcase
  end

  assign panel_ready = (state == S_ON);
  assign state_o     = state;

`ifdef LVDS_BL_PWM_EN
  localparam int DW = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DW-1:0] div_cnt;
  logic [7:0]    pwm_cnt;
  logic          pwm_q;

  // PWM counter starts from zero every time the backlight is switched on.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      div_cnt <= '0;
      pwm_cnt <= '0;
      pwm_q   <= 1'b0;
    end else begin
      pwm_q <= bl_en & (pwm_cnt < brightness);
      if (!bl_en) begin
        div_cnt <= '0;
        pwm_cnt <= '0;
      end else if (div_cnt == DW'(PWM_DIV - 1)) begin
        div_cnt <= '0;
        pwm_cnt <= pwm_cnt + 8'd1;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  assign bl_pwm = pwm_q;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
  assign bl_pwm = bl_en;
`endif

endmodule

// File: tb/tb_lvds_panel_power_seq.sv
// Directed bench for lvds_panel_power_seq: power-up/down timing, abort, underflow fault,
// asynchronous reset and backlight PWM (both with and without LVDS_BL_PWM_EN).
module tb_lvds_panel_power_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       panel_en;
  logic       vid_underflow;
  logic [7:0] brightness;
  logic       panel_vdd_en, lvds_tx_en, bl_en, bl_pwm, panel_ready, fault;
  logic [2:0] state_o;

  int checks = 0;
  int errors = 0;

  lvds_panel_power_seq dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .panel_en      (panel_en),
    .vid_underflow (vid_underflow),
    .brightness    (brightness),
    .panel_vdd_en  (panel_vdd_en),
    .lvds_tx_en    (lvds_tx_en),
    .bl_en         (bl_en),
    .bl_pwm        (bl_pwm),
    .panel_ready   (panel_ready),
    .fault         (fault),
    .state_o       (state_o)
  );

  always #5 clk = ~clk;

  wire [3:0] outs = {panel_vdd_en, lvds_tx_en, bl_en, panel_ready};

  // Expected {vdd, lvds, bl, ready} for each state, from the state table.
  function automatic logic [3:0] outs_of(input logic [2:0] s);
    case (s)
      3'd1:    outs_of = 4'b1000;
      3'd2:    outs_of = 4'b1100;
      3'd3:    outs_of = 4'b1111;
      3'd4:    outs_of = 4'b1100;
      3'd5:    outs_of = 4'b1000;
      default: outs_of = 4'b0000;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; panel_en = 1'b0; vid_underflow = 1'b0; brightness = 8'd0;
    repeat (3) step();
    checks++;
    if ({outs, bl_pwm, fault, state_o} !== 9'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b required 0", {outs, bl_pwm, fault, state_o});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (state_o !== 3'd0 || outs !== 4'd0) begin
      errors++;
      $display("FAIL reset_idle state %0d outs %b required 0/0000", state_o, outs);
    end
  endtask

  task automatic test_power_up();
    logic [2:0] exp_s;
    panel_en = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp_s = (k < 5) ? 3'd1 : (k < 8) ? 3'd2 : 3'd3;
      checks++;
      if (state_o !== exp_s || outs !== outs_of(exp_s)) begin
        errors++;
        $display("FAIL power_up edge %0d state %0d outs %b required %0d %b",
                 k, state_o, outs, exp_s, outs_of(exp_s));
      end
`ifndef LVDS_BL_PWM_EN
      checks++;
      if (bl_pwm !== bl_en) begin
        errors++;
        $display("FAIL pwm_follows_bl edge %0d bl_pwm %b required %b", k, bl_pwm, bl_en);
      end
`endif
    end
  endtask

  task automatic test_power_down();
    logic [2:0] exp_s [12] = '{3'd4, 3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6,
                               3'd0, 3'd1, 3'd1};
    panel_en = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++;
      if (state_o !== exp_s[k-1] || outs !== outs_of(exp_s[k-1])) begin
        errors++;
        $display("FAIL power_down edge %0d state %0d outs %b required %0d %b",
                 k, state_o, outs, exp_s[k-1], outs_of(exp_s[k-1]));
      end
      if (k == 6) panel_en = 1'b1;
    end
    panel_en = 1'b0;
    repeat (7) step();
    checks++;
    if (state_o !== 3'd0 || outs !== 4'd0) begin
      errors++;
      $display("FAIL power_down_settle state %0d outs %b required 0 0000", state_o, outs);
    end
  endtask

  task automatic test_abort_pulse();
    logic [2:0] exp_s [9] = '{3'd1, 3'd1, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0, 3'd0};
    panel_en = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (state_o !== exp_s[k-1] || outs !== outs_of(exp_s[k-1])) begin
        errors++;
        $display("FAIL abort_pulse edge %0d state %0d outs %b required %0d %b",
                 k, state_o, outs, exp_s[k-1], outs_of(exp_s[k-1]));
      end
      if (k == 2) panel_en = 1'b0;
    end
  endtask

  task automatic test_underflow();
    logic [2:0] exp_s [9] = '{3'd4, 3'd5, 3'd5, 3'd6, 3'd6, 3'd6, 3'd6, 3'd6, 3'd0};
    panel_en = 1'b1;
    repeat (8) step();
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL uf_reach_on state %0d required 3", state_o);
    end
    // Two runs of 7 separated by a clean cycle must not trip.
    for (int r = 0; r < 2; r++) begin
      vid_underflow = 1'b1;
      for (int k = 1; k <= 7; k++) begin
        step();
        checks++;
        if (state_o !== 3'd3 || fault !== 1'b0) begin
          errors++;
          $display("FAIL uf_below_limit run %0d cycle %0d state %0d fault %b required 3 0",
                   r, k, state_o, fault);
        end
      end
      vid_underflow = 1'b0;
      step();
    end
    vid_underflow = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      checks++;
      if (k < 8 && (state_o !== 3'd3 || fault !== 1'b0)) begin
        errors++;
        $display("FAIL uf_run cycle %0d state %0d fault %b required 3 0", k, state_o, fault);
      end else if (k == 8 && (state_o !== 3'd4 || fault !== 1'b1 || bl_en !== 1'b0)) begin
        errors++;
        $display("FAIL uf_trip state %0d fault %b bl %b required 4 1 0", state_o, fault, bl_en);
      end
    end
    vid_underflow = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      checks++;
      if (state_o !== exp_s[k-1] || fault !== 1'b1 || outs !== outs_of(exp_s[k-1])) begin
        errors++;
        $display("FAIL uf_shutdown edge %0d state %0d fault %b outs %b required %0d 1 %b",
                 k, state_o, fault, outs, exp_s[k-1], outs_of(exp_s[k-1]));
      end
    end
    repeat (4) step();
    checks++;
    if (state_o !== 3'd0 || fault !== 1'b1 || outs !== 4'd0) begin
      errors++;
      $display("FAIL uf_hold_off state %0d fault %b outs %b required 0 1 0000", state_o, fault, outs);
    end
    panel_en = 1'b0;
    step();
    checks++;
    if (fault !== 1'b0 || state_o !== 3'd0) begin
      errors++;
      $display("FAIL uf_clear fault %b state %0d required 0 0", fault, state_o);
    end
    panel_en = 1'b1;
    step();
    checks++;
    if (state_o !== 3'd1) begin
      errors++;
      $display("FAIL uf_restart state %0d required 1", state_o);
    end
    panel_en = 1'b0;
    repeat (7) step();
    checks++;
    if (state_o !== 3'd0) begin
      errors++;
      $display("FAIL uf_back_off state %0d required 0", state_o);
    end
  endtask

  task automatic test_reset_mid();
    panel_en = 1'b1;
    repeat (6) step();
    checks++;
    if (state_o !== 3'd2) begin
      errors++;
      $display("FAIL mid_reach_lvds state %0d required 2", state_o);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({outs, bl_pwm, state_o} !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset_async outs %b pwm %b state %0d required 0", outs, bl_pwm, state_o);
    end
    panel_en = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++;
    if (state_o !== 3'd0 || outs !== 4'd0) begin
      errors++;
      $display("FAIL mid_reset_release state %0d outs %b required 0 0000", state_o, outs);
    end
  endtask

  task automatic test_pwm();
    int highs;
    brightness = 8'd64;
    panel_en = 1'b1;
    repeat (8) step();
    checks++;
    if (state_o !== 3'd3) begin
      errors++;
      $display("FAIL pwm_reach_on state %0d required 3", state_o);
    end
`ifdef LVDS_BL_PWM_EN
    step(); step();
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      if (bl_pwm === 1'b1) highs++;
      step();
    end
    checks++;
    if (highs != 64) begin
      errors++;
      $display("FAIL pwm_duty_64 high %0d of 256 required 64", highs);
    end
    brightness = 8'd0;
    step(); step();
    highs = 0;
    for (int k = 0; k < 256; k++) begin
      if (bl_pwm !== 1'b0) highs++;
      step();
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL pwm_duty_0 high %0d of 256 required 0", highs);
    end
`else
    highs = 0;
    for (int k = 0; k < 20; k++) begin
      if (bl_pwm !== 1'b1) highs++;
      if (k == 10) brightness = 8'd0;
      step();
    end
    checks++;
    if (highs != 0) begin
      errors++;
      $display("FAIL pwm_equals_bl low cycles %0d required 0", highs);
    end
`endif
    panel_en = 1'b0;
    repeat (12) step();
    checks++;
    if (state_o !== 3'd0 || bl_pwm !== 1'b0) begin
      errors++;
      $display("FAIL pwm_off state %0d pwm %b required 0 0", state_o, bl_pwm);
    end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_power_down();
    test_abort_pulse();
    test_underflow();
    test_reset_mid();
    test_pwm();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
